phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000; cycles exec_btn_n must be stable before it is accepted.
REQ-002 SHALL have parameter LAST_PHASE, default 3'd4; final phase index (five phases 0..4).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 exec_btn_n  in  1  raw, asynchronous, active-low run/stop pushbutton.
REQ-007 running  in  1  run state from control_unit; 1 = processor executing.
REQ-008 stall  in  1  hold current phase (memory wait); 1 = hold.
REQ-009 halt_instr  in  1  decode flag: current instruction is HLT.
REQ-010 step_mode  in  1  1 = stop after every instruction.
REQ-011 phase  out  3  current phase index, 0..LAST_PHASE.
REQ-012 exec  out  1  debounced exec request, active-low, one-cycle pulse.
REQ-013 halt  out  1  stop request to control_unit, active-high, one-cycle pulse.
REQ-014 instr_done  out  1  one-cycle pulse on phase LAST_PHASE to 0 wrap.
REQ-015 instr_count  out  16  retired-instruction counter.

Function
REQ-016 Advance condition: adv = running & ~stall; phase SHALL increment by 1 per clock while adv is high.
REQ-017 When adv is high and phase == LAST_PHASE, phase SHALL wrap to 0 in the same cycle instr_done pulses.
REQ-018 When adv is low, phase SHALL hold its value; no phase skipping.
REQ-019 instr_count SHALL increment on each instr_done pulse and wrap from 16'hFFFF to 0.
REQ-020 exec_btn_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-021 The debouncer SHALL accept a new level only after the synchronized input has held that level for DEBOUNCE_CYCLES consecutive cycles; any change restarts the count.
REQ-022 exec SHALL be driven low for exactly one cycle on each accepted 1-to-0 transition; a held button SHALL produce no further pulses.
REQ-023 halt SHALL pulse one cycle after a wrap where halt_instr was high in phase LAST_PHASE, or where step_mode was high.
REQ-024 If a halt pulse and an exec pulse fall in the same cycle, halt SHALL be deferred one cycle; neither pulse is dropped.
REQ-025 At most one halt request SHALL be pending; a second request while one is pending is merged.
REQ-026 halt SHALL never be high while exec is low.

Reset
REQ-027 On reset: phase=0, exec=1, halt=0, instr_done=0, instr_count=0.
REQ-028 On reset, the debouncer state SHALL be set to released (1) with its counter cleared; the pending-halt flag SHALL be cleared.
REQ-029 Reset asserted mid-instruction SHALL return phase to 0 on the next edge, overriding adv.

Structure
REQ-030 A shared package SHALL hold the phase constants PH_FETCH=0, PH_DECODE=1, PH_EXEC=2, PH_MEM=3, PH_WB=4, plus the phase width (3).
REQ-031 The debouncer (synchronizer, counter, edge detect) SHALL be a sub-module named btn_debounce.

Verification
REQ-032 Run test: running=1, stall=0 for 12 cycles from reset. Required: phase = 0,1,2,3,4,0,1,... with instr_done high in cycles 5 and 10, and instr_count=2.
REQ-033 Stall test: stall=1 for 3 cycles while phase=2. Required: phase stays 2 for 3 cycles, then goes to 3; no instr_done during the stall.
REQ-034 Debounce test, with DEBOUNCE_CYCLES=4: 2-cycle glitch gives no exec pulse; a 10-cycle press gives exactly one exec low pulse, 6 cycles after the press (2 sync + 4 stable).
REQ-035 Halt test: halt_instr=1 during phase 4. Required: halt pulses for exactly one cycle after the wrap. With step_mode=1, halt pulses after every wrap.
REQ-036 Collision test: force exec pulse and halt request in the same cycle. Required: exec low in cycle N, halt high in cycle N+1.
REQ-037 Reset test: reset=1 at phase 3 with instr_count=7. Required: next edge gives phase=0, instr_count=0, exec=1, halt=0.

Source files
------------

// File: rtl/phase_sequencer_pkg.sv
// Shared phase constants for the instruction phase sequencer.
package phase_sequencer_pkg;
    localparam int PHASE_W = 3;
    typedef logic [PHASE_W-1:0] phase_t;

    localparam phase_t PH_FETCH  = 3'd0;
    localparam phase_t PH_DECODE = 3'd1;
    localparam phase_t PH_EXEC   = 3'd2;
    localparam phase_t PH_MEM    = 3'd3;
    localparam phase_t PH_WB     = 3'd4;
endpackage

// File: rtl/btn_debounce.sv
// Run/stop button conditioning: 2-flop synchronizer, stability counter and
// falling-edge detect producing a one-cycle active-low exec pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic fire,
    output logic exec
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2, level, accept;
    logic [CW-1:0] cnt;

    // accept on the DEBOUNCE_CYCLES-th consecutive cycle that s2 differs from level
    assign accept = (s2 != level) && (cnt == CNT_LAST);
    // fire is the next-cycle exec pulse; the top uses it to defer halt
    assign fire   = accept && level;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            exec  <= 1'b1;
        end else begin
            s1   <= btn_n;
            s2   <= s1;
            exec <= !fire;
            if (s2 == level || accept)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (accept)
                level <= s2;
        end
    end
endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: steps phases 0..LAST_PHASE, counts retired
// instructions and arbitrates halt requests against debounced exec pulses.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int     DEBOUNCE_CYCLES = 50000,
    parameter phase_t LAST_PHASE      = 3'd4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               exec_btn_n,
    input  logic               running,
    input  logic               stall,
    input  logic               halt_instr,
    input  logic               step_mode,
    output logic [PHASE_W-1:0] phase,
    output logic               exec,
    output logic               halt,
    output logic               instr_done,
    output logic [15:0]        instr_count
);
    logic adv, wrap, halt_req, halt_pend, fire;

    assign adv      = running && !stall;
    assign wrap     = adv && (phase == LAST_PHASE);
    assign halt_req = wrap && (halt_instr || step_mode);

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clock (clock),
        .reset (reset),
        .btn_n (exec_btn_n),
        .fire  (fire),
        .exec  (exec)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            phase       <= PH_FETCH;
            instr_done  <= 1'b0;
            instr_count <= '0;
            halt        <= 1'b0;
            halt_pend   <= 1'b0;
        end else begin
            instr_done <= wrap;
            if (adv)
                phase <= wrap ? PH_FETCH : phase + PHASE_W'(1);
            if (wrap)
                instr_count <= instr_count + 16'd1;
            // a pending halt waits out any cycle in which exec goes low
            halt      <= halt_pend && !fire;
            halt_pend <= (halt_pend && fire) || halt_req;
        end
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer against a cycle-level behavioural model.
module tb_phase_sequencer;
    localparam int         DB   = 4;
    localparam int         NPH  = 5;
    localparam logic [2:0] LAST = 3'd4;

    logic        clock = 0, reset = 1, exec_btn_n = 1, running = 0, stall = 0;
    logic        halt_instr = 0, step_mode = 0;
    logic [2:0]  phase;
    logic        exec, halt, instr_done;
    logic [15:0] instr_count;
    logic [21:0] obs;
    int          checks = 0, passes = 0;

    // behavioural model state
    int   m_phase, m_count;
    logic m_exec, m_halt, m_done, m_level, m_pend, m_col;
    logic rq[$];

    phase_sequencer #(.DEBOUNCE_CYCLES(DB), .LAST_PHASE(LAST)) dut (
        .clock(clock), .reset(reset), .exec_btn_n(exec_btn_n), .running(running),
        .stall(stall), .halt_instr(halt_instr), .step_mode(step_mode), .phase(phase),
        .exec(exec), .halt(halt), .instr_done(instr_done), .instr_count(instr_count)
    );

    always #5 clock = ~clock;
    assign obs = {phase, exec, halt, instr_done, instr_count};

    function automatic logic [21:0] mexp();
        return {3'(m_phase), m_exec, m_halt, m_done, 16'(m_count)};
    endfunction

    // one clock: update the model at the rising edge, return at the falling edge
    task automatic tick();
        bit all_new, fire, wrap;
        @(posedge clock);
        m_col = 0;
        if (reset) begin
            m_phase = 0; m_count = 0; m_exec = 1; m_halt = 0; m_done = 0;
            m_level = 1; m_pend = 0;
            rq.delete();
            for (int i = 0; i <= DB; i++) rq.push_back(1'b1);
        end else begin
            // button is accepted once its synchronized level held DB cycles
            all_new = 1;
            for (int i = 0; i < DB; i++) if (rq[i] == m_level) all_new = 0;
            fire = all_new && m_level;
            if (all_new) m_level = ~m_level;
            wrap   = running && !stall && m_phase == NPH - 1;
            m_col  = m_pend && fire;
            m_halt = m_pend && !fire;
            m_pend = (m_pend && fire) || (wrap && (halt_instr || step_mode));
            m_exec = ~fire;
            m_done = wrap;
            if (running && !stall) m_phase = (m_phase + 1) % NPH;
            if (wrap) m_count = (m_count + 1) % 65536;
            void'(rq.pop_front());
            rq.push_back(exec_btn_n);
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1; running = 0; stall = 0; halt_instr = 0; step_mode = 0; exec_btn_n = 1;
        tick(); tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; running = 1; halt_instr = 1; step_mode = 1; exec_btn_n = 0;
        tick(); tick(); tick();
        checks++;
        if (obs !== {3'd0, 1'b1, 1'b0, 1'b0, 16'd0})
            $display("FAIL reset_state got=%h exp=%h", obs, {3'd0, 1'b1, 1'b0, 1'b0, 16'd0});
        else passes++;
        do_reset();
    endtask

    task automatic test_run();
        do_reset();
        running = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (phase !== 3'(i % 5) || instr_done !== (i == 5 || i == 10) || obs !== mexp())
                $display("FAIL run cyc=%0d phase=%0d done=%b got=%h exp=%h", i, phase, instr_done, obs, mexp());
            else passes++;
        end
        checks++;
        if (instr_count !== 16'd2) $display("FAIL run_count got=%0d exp=2", instr_count);
        else passes++;
    endtask

    // continues from test_run, which leaves phase at 2
    task automatic test_stall();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (phase !== 3'd2 || instr_done !== 1'b0 || obs !== mexp())
                $display("FAIL stall cyc=%0d phase=%0d done=%b exp_phase=2", i, phase, instr_done);
            else passes++;
        end
        stall = 0;
        tick();
        checks++;
        if (phase !== 3'd3 || obs !== mexp()) $display("FAIL stall_release phase=%0d exp=3", phase);
        else passes++;
    endtask

    task automatic test_debounce();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            exec_btn_n = (i < 2) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (exec !== 1'b1 || obs !== mexp()) $display("FAIL glitch cyc=%0d exec=%b exp=1", i, exec);
            else passes++;
        end
        exec_btn_n = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (exec !== (i == 6 ? 1'b0 : 1'b1) || obs !== mexp())
                $display("FAIL press cyc=%0d exec=%b exp=%b", i, exec, (i == 6 ? 1'b0 : 1'b1));
            else passes++;
        end
        exec_btn_n = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (exec !== 1'b1 || obs !== mexp()) $display("FAIL release cyc=%0d exec=%b exp=1", i, exec);
            else passes++;
        end
    endtask

    task automatic test_halt();
        logic pd, hexp;
        do_reset();
        running = 1;
        for (int i = 0; i < 25; i++) begin
            halt_instr = (m_phase == NPH - 1) && (m_count % 2 == 0);
            tick();
            checks++;
            if (obs !== mexp()) $display("FAIL halt_instr cyc=%0d got=%h exp=%h", i, obs, mexp());
            else passes++;
        end
        halt_instr = 0; step_mode = 1; pd = m_done;
        for (int i = 0; i < 20; i++) begin
            tick();
            hexp = pd; pd = m_done;
            checks++;
            if (halt !== hexp || obs !== mexp()) $display("FAIL step cyc=%0d halt=%b exp=%b", i, halt, hexp);
            else passes++;
        end
    endtask

    // sweeps the press time across all five phase residues so one exec pulse
    // lands on the cycle a step-mode halt would otherwise issue
    task automatic test_collision();
        bit col_prev;
        do_reset();
        running = 1; step_mode = 1; col_prev = 0;
        for (int off = 0; off < 5; off++) begin
            for (int c = 0; c < 20; c++) begin
                exec_btn_n = !(c >= off && c < off + 8);
                tick();
                checks++;
                if (obs !== mexp()) $display("FAIL collision off=%0d c=%0d got=%h exp=%h", off, c, obs, mexp());
                else passes++;
                if (col_prev) begin
                    checks++;
                    if (halt !== 1'b1 || exec !== 1'b1)
                        $display("FAIL collision_defer halt=%b exec=%b exp halt=1 exec=1", halt, exec);
                    else passes++;
                end
                if (m_col) begin
                    checks++;
                    if (exec !== 1'b0 || halt !== 1'b0)
                        $display("FAIL collision_slot exec=%b halt=%b exp exec=0 halt=0", exec, halt);
                    else passes++;
                end
                col_prev = m_col;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        running = 1; n = 0;
        while (!(m_count == 7 && m_phase == 3) && n < 100) begin
            tick(); n++;
        end
        checks++;
        if (phase !== 3'd3 || instr_count !== 16'd7)
            $display("FAIL reset_mid_setup phase=%0d count=%0d exp 3/7", phase, instr_count);
        else passes++;
        reset = 1;
        tick();
        checks++;
        if (obs !== {3'd0, 1'b1, 1'b0, 1'b0, 16'd0})
            $display("FAIL reset_mid got=%h exp=%h", obs, {3'd0, 1'b1, 1'b0, 1'b0, 16'd0});
        else passes++;
        reset = 0;
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            running    = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            halt_instr = ($urandom_range(0, 9) < 3);
            step_mode  = ($urandom_range(0, 9) == 0);
            if (hold == 0) begin
                exec_btn_n = $urandom_range(0, 1);
                hold = $urandom_range(1, 9);
            end
            hold--;
            tick();
            checks++;
            if (obs !== mexp()) $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, mexp());
            else passes++;
        end
        reset = 0;
    endtask

    initial begin
        tick();
        test_reset();
        test_run();
        test_stall();
        test_debounce();
        test_halt();
        test_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
